// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-client memory arbiter: memory op codes, FSM state
// encodings, client indices and the round-robin helper. Feature macro: MEM_ARB_RR_EN.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        GET_CONTENTS = 2'd0,
        SET_CONTENTS = 2'd1,
        GET_FREE     = 2'd2
    } mem_func_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    // Round-robin hands a contested grant to whichever client did not win last time.
    function automatic logic rr_choice(input logic last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way chooser. Defining MEM_ARB_RR_EN selects round-robin on a
// simultaneous request; otherwise client 0 has fixed priority.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic pick
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        valid = req0 | req1;
        pick  = CLIENT0;
        if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            pick = rr_choice(last_grant);
`else
            pick = CLIENT0;
`endif
        end else if (req1) begin
            pick = CLIENT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter/sequencer in front of memory_unit: grants one request at a time,
// drives a single execute pulse, waits for the ready low/high cycle and acks the owner.
// Contested-grant policy is selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              c0_req,
    input  logic [1:0]        c0_func,
    input  logic [ADDR_W-1:0] c0_addr1,
    input  logic [ADDR_W-1:0] c0_addr2,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    input  logic              c1_req,
    input  logic [1:0]        c1_func,
    input  logic [ADDR_W-1:0] c1_addr1,
    input  logic [ADDR_W-1:0] c1_addr2,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic [ADDR_W-1:0] rsp_free_addr,
    output logic              busy,
    output logic [1:0]        m_func,
    output logic              m_execute,
    output logic [ADDR_W-1:0] m_address1,
    output logic [ADDR_W-1:0] m_address2,
    output logic [DATA_W-1:0] m_write_data,
    input  logic              m_is_ready,
    input  logic [DATA_W-1:0] m_read_data1,
    input  logic [DATA_W-1:0] m_read_data2,
    input  logic [ADDR_W-1:0] m_free_addr
);

    logic [1:0] state;
    logic       grant;
    logic       last_grant;
    logic       seen_low;
    logic       pick_valid;
    logic       pick;

    mem_arb_pick u_pick (
        .req0       (c0_req),
        .req1       (c1_req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .pick       (pick)
    );

    // Completion requires memory to be seen busy at least once after the execute
    // pulse, so a stale ready from before the op cannot end it early.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            grant         <= CLIENT0;
            last_grant    <= CLIENT1;
            seen_low      <= 1'b0;
            c0_ack        <= 1'b0;
            c1_ack        <= 1'b0;
            busy          <= 1'b0;
            rsp_data1     <= '0;
            rsp_data2     <= '0;
            rsp_free_addr <= '0;
            m_func        <= '0;
            m_execute     <= 1'b0;
            m_address1    <= '0;
            m_address2    <= '0;
            m_write_data  <= '0;
        end else if (power) begin
            c0_ack    <= 1'b0;
            c1_ack    <= 1'b0;
            m_execute <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m_is_ready && pick_valid) begin
                        grant        <= pick;
                        busy         <= 1'b1;
                        m_func       <= (pick == CLIENT1) ? c1_func  : c0_func;
                        m_address1   <= (pick == CLIENT1) ? c1_addr1 : c0_addr1;
                        m_address2   <= (pick == CLIENT1) ? c1_addr2 : c0_addr2;
                        m_write_data <= (pick == CLIENT1) ? c1_wdata : c0_wdata;
                        m_execute    <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    seen_low <= 1'b0;
                    state    <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (!m_is_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        rsp_data1     <= m_read_data1;
                        rsp_data2     <= m_read_data2;
                        rsp_free_addr <= m_free_addr;
                        if (grant == CLIENT1) begin
                            c1_ack <= 1'b1;
                        end else begin
                            c0_ack <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy       <= 1'b0;
                    last_grant <= grant;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory_unit stand-in, directed
// vector table, contested-request pairs, randomized ops and power/reset/init corners.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam logic [ADDR_W-1:0] FREE_BASE = 10'd100;
    localparam int ACK_TIMEOUT = 300;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic power = 1'b1;

    logic              c0_req = 1'b0, c1_req = 1'b0;
    logic [1:0]        c0_func = '0, c1_func = '0;
    logic [ADDR_W-1:0] c0_addr1 = '0, c0_addr2 = '0, c1_addr1 = '0, c1_addr2 = '0;
    logic [DATA_W-1:0] c0_wdata = '0, c1_wdata = '0;
    logic              c0_ack, c1_ack, busy, m_execute;
    logic [DATA_W-1:0] rsp_data1, rsp_data2, m_write_data;
    logic [ADDR_W-1:0] rsp_free_addr, m_address1, m_address2;
    logic [1:0]        m_func;

    logic              mem_ready;
    logic [DATA_W-1:0] mem_rd1, mem_rd2;
    logic [ADDR_W-1:0] mem_free;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .power(power),
        .c0_req(c0_req), .c0_func(c0_func), .c0_addr1(c0_addr1), .c0_addr2(c0_addr2),
        .c0_wdata(c0_wdata), .c0_ack(c0_ack),
        .c1_req(c1_req), .c1_func(c1_func), .c1_addr1(c1_addr1), .c1_addr2(c1_addr2),
        .c1_wdata(c1_wdata), .c1_ack(c1_ack),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_free_addr(rsp_free_addr),
        .busy(busy), .m_func(m_func), .m_execute(m_execute),
        .m_address1(m_address1), .m_address2(m_address2), .m_write_data(m_write_data),
        .m_is_ready(mem_ready), .m_read_data1(mem_rd1), .m_read_data2(mem_rd2),
        .m_free_addr(mem_free)
    );

    // Memory stand-in: ready low for 'lat' cycles after an execute, op applied on completion.
    int                init_cycles = 3;
    int                lat = 2;
    int                init_cnt, busy_cnt;
    logic [1:0]        pf;
    logic [ADDR_W-1:0] pa1, pa2, free_ptr;
    logic [DATA_W-1:0] pwd;
    logic [DATA_W-1:0] store [0:1023];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ready <= 1'b0;
            init_cnt  <= init_cycles + 1;
            busy_cnt  <= 0;
            free_ptr  <= FREE_BASE;
            mem_rd1   <= '0;
            mem_rd2   <= '0;
            mem_free  <= '0;
            pf <= '0; pa1 <= '0; pa2 <= '0; pwd <= '0;
            for (int i = 0; i < 1024; i++) store[i] <= '0;
        end else if (init_cnt != 0) begin
            init_cnt <= init_cnt - 1;
            if (init_cnt == 1) mem_ready <= 1'b1;
        end else if (mem_ready) begin
            if (m_execute) begin
                mem_ready <= 1'b0;
                busy_cnt  <= lat;
                pf <= m_func; pa1 <= m_address1; pa2 <= m_address2; pwd <= m_write_data;
            end
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt  <= 0;
            mem_ready <= 1'b1;
            case (pf)
                GET_CONTENTS: begin mem_rd1 <= store[pa1]; mem_rd2 <= store[pa2]; end
                SET_CONTENTS: store[pa1] <= pwd;
                GET_FREE: begin mem_free <= free_ptr; free_ptr <= free_ptr + pwd[ADDR_W-1:0]; end
                default: ;
            endcase
        end
    end

    int   exec_count = 0, exec_double = 0, ack0_count = 0, ack1_count = 0;
    logic prev_exec = 1'b0;

    always @(negedge clk) begin
        if (m_execute) begin
            exec_count++;
            if (prev_exec) exec_double++;
        end
        prev_exec = m_execute;
        if (c0_ack) ack0_count++;
        if (c1_ack) ack1_count++;
    end

    // Reference model: flat memory image, free pointer and the last winner.
    logic [DATA_W-1:0] ref_mem [int];
    logic [ADDR_W-1:0] ref_free = FREE_BASE;
    logic              ref_last = 1'b1;

    typedef struct {
        logic              client;
        logic [1:0]        func;
        logic [ADDR_W-1:0] a1, a2;
        logic [DATA_W-1:0] wd;
        int                lat;
        logic [DATA_W-1:0] e1, e2;
        logic [ADDR_W-1:0] ef;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [255:0] packOut();
        return 256'({c0_ack, c1_ack, busy, m_execute, m_func, m_address1, m_address2,
                     rsp_free_addr, m_write_data, rsp_data1, rsp_data2});
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic refReset();
        ref_mem.delete();
        ref_free = FREE_BASE;
        ref_last = 1'b1;
    endtask

    task automatic refApply(input logic [1:0] f, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                            input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] e1,
                            output logic [DATA_W-1:0] e2, output logic [ADDR_W-1:0] ef);
        e1 = '0; e2 = '0; ef = '0;
        if (f == GET_CONTENTS) begin
            e1 = ref_mem.exists(int'(a1)) ? ref_mem[int'(a1)] : '0;
            e2 = ref_mem.exists(int'(a2)) ? ref_mem[int'(a2)] : '0;
        end else if (f == SET_CONTENTS) begin
            ref_mem[int'(a1)] = wd;
        end else if (f == GET_FREE) begin
            ef = ref_free;
            ref_free = ref_free + wd[ADDR_W-1:0];
        end
    endtask

    task automatic checkRsp(input string tag, input logic [1:0] f, input logic [DATA_W-1:0] e1,
                            input logic [DATA_W-1:0] e2, input logic [ADDR_W-1:0] ef);
        if (f == GET_CONTENTS) begin
            checkOutput({tag, "_data1"}, rsp_data1, e1);
            checkOutput({tag, "_data2"}, rsp_data2, e2);
        end else if (f == GET_FREE) begin
            checkOutput({tag, "_free_addr"}, 64'(rsp_free_addr), 64'(ef));
        end
    endtask

    task automatic driveReq(input logic c, input logic [1:0] f, input logic [ADDR_W-1:0] a1,
                            input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] wd);
        if (c) begin
            c1_func = f; c1_addr1 = a1; c1_addr2 = a2; c1_wdata = wd; c1_req = 1'b1;
        end else begin
            c0_func = f; c0_addr1 = a1; c0_addr2 = a2; c0_wdata = wd; c0_req = 1'b1;
        end
    endtask

    task automatic dropReq(input logic c);
        if (c) c1_req = 1'b0;
        else   c0_req = 1'b0;
    endtask

    task automatic waitAck(output bit got, output logic who, output int cycles);
        got = 1'b0; who = 1'b0; cycles = 0;
        while (!got && cycles < ACK_TIMEOUT) begin
            @(posedge clk); #1;
            cycles++;
            if (c0_ack || c1_ack) begin
                got = 1'b1;
                who = c1_ack;
            end
        end
    endtask

    task automatic finishOp(input logic c, input logic [1:0] f, input logic [ADDR_W-1:0] a1,
                            input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] wd, input int l,
                            input bit chk_lat, input int exec0, input int ack00, input int ack10);
        bit got; logic who; int cyc;
        logic [DATA_W-1:0] e1, e2; logic [ADDR_W-1:0] ef;
        waitAck(got, who, cyc);
        dropReq(c);
        checkOutput("ack_seen", 64'(got), 64'd1);
        if (got) checkOutput("ack_client", 64'(who), 64'(c));
        refApply(f, a1, a2, wd, e1, e2, ef);
        ref_last = c;
        checkRsp("op", f, e1, e2, ef);
        if (chk_lat) checkOutput("latency", 64'(cyc), 64'(l + 3));
        checkOutput("m_func_hold", 64'(m_func), 64'(f));
        checkOutput("m_addr1_hold", 64'(m_address1), 64'(a1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("exec_pulses", 64'(exec_count - exec0), 64'd1);
        checkOutput("ack0_pulses", 64'(ack0_count - ack00), c ? 64'd0 : 64'd1);
        checkOutput("ack1_pulses", 64'(ack1_count - ack10), c ? 64'd1 : 64'd0);
    endtask

    task automatic applyStimulus(input logic c, input logic [1:0] f, input logic [ADDR_W-1:0] a1,
                                 input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] wd,
                                 input int l, input bit chk_lat);
        int exec0, ack00, ack10;
        lat = l;
        exec0 = exec_count; ack00 = ack0_count; ack10 = ack1_count;
        driveReq(c, f, a1, a2, wd);
        finishOp(c, f, a1, a2, wd, l, chk_lat, exec0, ack00, ack10);
    endtask

    task automatic applyPair(input logic [1:0] f0, input logic [ADDR_W-1:0] a10, input logic [ADDR_W-1:0] a20,
                             input logic [DATA_W-1:0] wd0, input logic [1:0] f1, input logic [ADDR_W-1:0] a11,
                             input logic [ADDR_W-1:0] a21, input logic [DATA_W-1:0] wd1, input int l);
        int exec0, ack00, ack10, cyc;
        bit got; logic who, first, cur;
        logic [DATA_W-1:0] e1, e2; logic [ADDR_W-1:0] ef;
        lat = l;
        exec0 = exec_count; ack00 = ack0_count; ack10 = ack1_count;
`ifdef MEM_ARB_RR_EN
        first = ~ref_last;
`else
        first = 1'b0;
`endif
        driveReq(1'b0, f0, a10, a20, wd0);
        driveReq(1'b1, f1, a11, a21, wd1);
        for (int k = 0; k < 2; k++) begin
            cur = (k == 0) ? first : ~first;
            waitAck(got, who, cyc);
            dropReq(cur);
            checkOutput("pair_ack_seen", 64'(got), 64'd1);
            if (got) checkOutput("pair_order", 64'(who), 64'(cur));
            if (cur) refApply(f1, a11, a21, wd1, e1, e2, ef);
            else     refApply(f0, a10, a20, wd0, e1, e2, ef);
            ref_last = cur;
            checkRsp("pair", cur ? f1 : f0, e1, e2, ef);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pair_exec_pulses", 64'(exec_count - exec0), 64'd2);
        checkOutput("pair_ack0_pulses", 64'(ack0_count - ack00), 64'd1);
        checkOutput("pair_ack1_pulses", 64'(ack1_count - ack10), 64'd1);
    endtask

    task automatic doReset(input int init);
        init_cycles = init;
        c0_req = 1'b0; c1_req = 1'b0;
        rst = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        refReset();
    endtask

    initial begin
        int exec0, ack00, ack10, bad, n;
        logic [255:0] snap;
        logic c;
        logic [1:0] f, f1;
        logic [ADDR_W-1:0] a1, a2, b1, b2;
        logic [DATA_W-1:0] wd, wd1;

        vecs[0] = '{1'b0, SET_CONTENTS, 10'd5, 10'd0, 64'hABCD, 2, 64'd0, 64'd0, 10'd0};
        vecs[1] = '{1'b0, GET_CONTENTS, 10'd5, 10'd0, 64'd0, 3, 64'hABCD, 64'd0, 10'd0};
        vecs[2] = '{1'b1, SET_CONTENTS, 10'd7, 10'd0, 64'h1234_5678_9ABC_DEF0, 1, 64'd0, 64'd0, 10'd0};
        vecs[3] = '{1'b1, GET_CONTENTS, 10'd7, 10'd5, 64'd0, 4, 64'h1234_5678_9ABC_DEF0, 64'hABCD, 10'd0};
        vecs[4] = '{1'b1, GET_FREE, 10'd0, 10'd0, 64'd4, 2, 64'd0, 64'd0, 10'd100};
        vecs[5] = '{1'b1, GET_FREE, 10'd0, 10'd0, 64'd4, 2, 64'd0, 64'd0, 10'd104};
        vecs[6] = '{1'b0, GET_FREE, 10'd0, 10'd0, 64'd10, 3, 64'd0, 64'd0, 10'd108};
        vecs[7] = '{1'b0, GET_CONTENTS, 10'd0, 10'd7, 64'd0, 1, 64'd0, 64'h1234_5678_9ABC_DEF0, 10'd0};

        init_cycles = 3;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs_zero", 64'(|packOut()), 64'd0);
        rst = 1'b1;
        refReset();
        repeat (6) @(posedge clk);
        #1;
        checkOutput("post_reset_idle", 64'(|packOut()), 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].client, vecs[i].func, vecs[i].a1, vecs[i].a2, vecs[i].wd, vecs[i].lat, 1'b1);
            if (vecs[i].func == GET_CONTENTS) begin
                checkOutput("tbl_data1", rsp_data1, vecs[i].e1);
                checkOutput("tbl_data2", rsp_data2, vecs[i].e2);
            end else if (vecs[i].func == GET_FREE) begin
                checkOutput("tbl_free_addr", 64'(rsp_free_addr), 64'(vecs[i].ef));
            end
        end

        applyPair(GET_CONTENTS, 10'd5, 10'd7, 64'd0, GET_CONTENTS, 10'd7, 10'd5, 64'd0, 2);
        applyPair(GET_CONTENTS, 10'd7, 10'd0, 64'd0, GET_CONTENTS, 10'd5, 10'd5, 64'd0, 3);

        for (int i = 0; i < 40; i++) begin
            c  = 1'($urandom_range(0, 1));
            f  = 2'($urandom_range(0, 2));
            a1 = 10'($urandom_range(0, 31));
            a2 = 10'($urandom_range(0, 31));
            wd = (f == GET_FREE) ? 64'($urandom_range(1, 8)) : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                f1  = 2'($urandom_range(0, 2));
                b1  = 10'($urandom_range(0, 31));
                b2  = 10'($urandom_range(0, 31));
                wd1 = (f1 == GET_FREE) ? 64'($urandom_range(1, 8)) : {$urandom, $urandom};
                applyPair(f, a1, a2, wd, f1, b1, b2, wd1, int'($urandom_range(1, 5)));
            end else begin
                applyStimulus(c, f, a1, a2, wd, int'($urandom_range(1, 5)), 1'b1);
            end
        end

        // Power dropped mid-BUSY: everything holds, ack only after power returns.
        lat = 6;
        exec0 = exec_count; ack00 = ack0_count; ack10 = ack1_count;
        driveReq(1'b0, GET_CONTENTS, 10'd5, 10'd7, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        power = 1'b0;
        snap = packOut();
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (packOut() !== snap) bad++;
        end
        checkOutput("power_frozen", 64'(bad), 64'd0);
        checkOutput("power_no_ack", 64'((ack0_count - ack00) + (ack1_count - ack10)), 64'd0);
        power = 1'b1;
        finishOp(1'b0, GET_CONTENTS, 10'd5, 10'd7, 64'd0, 6, 1'b0, exec0, ack00, ack10);

        // Reset asserted while BUSY: in-flight SET is dropped with no ack.
        lat = 20;
        ack00 = ack0_count; ack10 = ack1_count;
        driveReq(1'b1, SET_CONTENTS, 10'd9, 10'd0, 64'hDEAD);
        repeat (4) @(posedge clk);
        #1;
        init_cycles = 4;
        rst = 1'b0;
        c1_req = 1'b0;
        #1;
        checkOutput("rst_mid_busy_zero", 64'(|packOut()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        refReset();
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rst_no_ack", 64'((ack0_count - ack00) + (ack1_count - ack10)), 64'd0);
        applyStimulus(1'b1, GET_CONTENTS, 10'd9, 10'd9, 64'd0, 2, 1'b1);
        applyStimulus(1'b0, GET_FREE, 10'd0, 10'd0, 64'd4, 2, 1'b1);
        checkOutput("rst_free_restart", 64'(rsp_free_addr), 64'(FREE_BASE));

        // Request raised while memory is still initialising.
        doReset(8);
        lat = 2;
        exec0 = exec_count; ack00 = ack0_count; ack10 = ack1_count;
        driveReq(1'b0, GET_FREE, 10'd0, 10'd0, 64'd3);
        n = 0;
        while (!mem_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("init_ready_rose", 64'(mem_ready), 64'd1);
        checkOutput("init_no_execute", 64'(exec_count - exec0), 64'd0);
        finishOp(1'b0, GET_FREE, 10'd0, 10'd0, 64'd3, 2, 1'b0, exec0, ack00, ack10);

        checkOutput("exec_single_cycle", 64'(exec_double), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
